// File: rtl/execute_stage.sv
// execute_stage: RV32I execute stage with ALU, branch resolution, PC redirect,
// wrong-path squash and the EX/MEM pipeline register.
module execute_stage #(
    parameter int SQUASH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_in1,
    input  logic [31:0] alu_in2,
    input  logic [3:0]  funct3_alu,
    input  logic [31:0] pc2ex,
    input  logic [6:0]  op_code2ex,
    input  logic [2:0]  funct3,
    input  logic [31:0] immidiate_ex,
    input  logic        data_mem_en_idex,
    input  logic        data_mem_we_idex,
    input  logic        gpr_en_idex,
    input  logic        gpr_we_idex,
    input  logic [31:0] rs2_idex,
    input  logic [4:0]  addr_rd_idex,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] alu_out_exmem,
    output logic [31:0] rs2_exmem,
    output logic [2:0]  funct3_exmem,
    output logic        data_mem_en_exmem,
    output logic        data_mem_we_exmem,
    output logic        gpr_en_exmem,
    output logic        gpr_we_exmem,
    output logic [4:0]  addr_rd_exmem
);
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [1:0] SQ_LOAD = 2'(SQUASH_CYCLES);

    typedef enum logic {IDLE, SQUASH} state_t;

    state_t      state, state_nxt;
    logic [1:0]  squash_cnt, cnt_nxt;
    logic [31:0] sum, alu_res, result;
    logic [4:0]  sh;
    logic        cond, is_br, is_jal, is_jalr, squash_active;

    assign sum = alu_in1 + alu_in2;
    assign sh  = alu_in2[4:0];

    always_comb begin
        alu_res = sum;
        case (funct3_alu)
            4'b1000: alu_res = alu_in1 - alu_in2;
            4'b0001: alu_res = alu_in1 << sh;
            4'b0010: alu_res = {31'b0, $signed(alu_in1) < $signed(alu_in2)};
            4'b0011: alu_res = {31'b0, alu_in1 < alu_in2};
            4'b0100: alu_res = alu_in1 ^ alu_in2;
            4'b0101: alu_res = alu_in1 >> sh;
            4'b1101: alu_res = $signed(alu_in1) >>> sh;
            4'b0110: alu_res = alu_in1 | alu_in2;
            4'b0111: alu_res = alu_in1 & alu_in2;
            default: alu_res = sum;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = alu_in1 == alu_in2;
            3'b001:  cond = alu_in1 != alu_in2;
            3'b100:  cond = $signed(alu_in1) < $signed(alu_in2);
            3'b101:  cond = $signed(alu_in1) >= $signed(alu_in2);
            3'b110:  cond = alu_in1 < alu_in2;
            3'b111:  cond = alu_in1 >= alu_in2;
            default: cond = 1'b0;
        endcase
    end

    assign is_br         = op_code2ex == OP_BR;
    assign is_jal        = op_code2ex == OP_JAL;
    assign is_jalr       = op_code2ex == OP_JALR;
    assign squash_active = state == SQUASH;
    assign result        = (is_jal | is_jalr) ? pc2ex + 32'd4 : alu_res;

    // Wrong-path instructions and anything during reset must never steer fetch.
    assign redirect_valid = ((is_br & cond) | is_jal | is_jalr) & ~squash_active & ~rst;
    assign redirect_pc    = !redirect_valid ? 32'd0 :
                            is_jalr         ? sum & 32'hFFFF_FFFE :
                            is_jal          ? sum :
                                              pc2ex + immidiate_ex;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = squash_cnt;
        if (state == IDLE) begin
            state_nxt = redirect_valid ? SQUASH : IDLE;
            cnt_nxt   = redirect_valid ? SQ_LOAD : squash_cnt;
        end else begin
            cnt_nxt   = squash_cnt - 2'd1;
            state_nxt = (squash_cnt == 2'd1) ? IDLE : SQUASH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            squash_cnt        <= 2'd0;
            alu_out_exmem     <= 32'd0;
            rs2_exmem         <= 32'd0;
            funct3_exmem      <= 3'd0;
            addr_rd_exmem     <= 5'd0;
            data_mem_en_exmem <= 1'b0;
            data_mem_we_exmem <= 1'b0;
            gpr_en_exmem      <= 1'b0;
            gpr_we_exmem      <= 1'b0;
        end else begin
            state             <= state_nxt;
            squash_cnt        <= cnt_nxt;
            alu_out_exmem     <= result;
            rs2_exmem         <= rs2_idex;
            funct3_exmem      <= funct3;
            addr_rd_exmem     <= addr_rd_idex;
            data_mem_en_exmem <= ~squash_active & data_mem_en_idex;
            data_mem_we_exmem <= ~squash_active & data_mem_we_idex;
            gpr_en_exmem      <= ~squash_active & gpr_en_idex;
            gpr_we_exmem      <= ~squash_active & gpr_we_idex & |addr_rd_idex;
        end
    end
endmodule
